ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the single-cycle CPU. It owns the program counter and drives the byte address into the combinational instruction ROM (word index = address[7:2]).
- It captures each returned word, with its PC, into a small queue. The queue is presented to decode over a valid/ready handshake.
- Execute-stage branch and jump redirects flush the queue. Fetches outside ROM space and misaligned targets are trapped.

---
 rtl/ifetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
//   Owns the program counter and drives it straight onto the combinational
//   instruction ROM address. Each returned word is queued together with its
//   PC and handed to decode over a valid/ready handshake. Execute-stage
//   redirects flush the queue and reload the PC. Out-of-range fetches and
//   misaligned redirect targets park the block in a sticky FAULT state.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   fetch_en            level-sensitive run request
//   rom_addr / rom_inst ROM byte address (== PC) and its combinational data
//   redirect_valid/_pc  taken branch/jump and its byte target
//   out_valid/ready     queue-head handshake toward decode
//   out_inst / out_pc   queue-head payload (zero when the queue is empty)
//   fifo_count          queue occupancy
//   fault               sticky trap flag
//   retire_cnt          number of handshaked instructions, wraps at 2^16
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ROM_WORDS  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_en,
  output logic [31:0]                   rom_addr,
  input  logic [31:0]                   rom_inst,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_inst,
  output logic [31:0]                   out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fault,
  output logic [15:0]                   retire_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [31:0]   PC_LIMIT = 32'(ROM_WORDS * 4);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [31:0]   pc_reg;
  logic [1:0]    state_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          fault_reg;
  logic [15:0]   retire_reg;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic redirect_eff;
  logic misaligned;
  logic in_range;
  logic pop;
  logic push;
  logic out_of_range;

  // A redirect arriving while faulted is ignored entirely, including its
  // suppression of the pop.
  assign redirect_eff = redirect_valid && (state_reg != FAULT);
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign in_range     = (pc_reg < PC_LIMIT);

  assign out_valid    = (count_reg != '0);
  assign pop          = out_valid && out_ready && !redirect_eff;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push         = (state_reg == RUN) && !redirect_valid && in_range &&
                        ((count_reg < DEPTH_C) || pop);
  assign out_of_range = (state_reg == RUN) && !redirect_valid && !in_range;

  assign rom_addr   = pc_reg;
  assign fifo_count = count_reg;
  assign fault      = fault_reg;
  assign retire_cnt = retire_reg;
  assign out_inst   = out_valid ? inst_mem[rd_ptr_reg] : 32'h0;
  assign out_pc     = out_valid ? pc_mem[rd_ptr_reg]   : 32'h0;

  // Queue storage carries no reset; emptiness is tracked by count_reg and
  // the head outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= rom_inst;
      pc_mem[wr_ptr_reg]   <= pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fault_reg  <= 1'b0;
      retire_reg <= 16'h0;
    end else if (redirect_eff) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      if (misaligned) begin
        state_reg <= FAULT;
        fault_reg <= 1'b1;
      end else begin
        pc_reg <= redirect_pc;
      end
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        pc_reg     <= pc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        retire_reg <= retire_reg + 16'd1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end

      case (state_reg)
        IDLE: begin
          if (fetch_en) state_reg <= RUN;
        end
        RUN: begin
          // Running off the end of ROM traps even if fetch_en just dropped.
          if (out_of_range) begin
            state_reg <= FAULT;
            fault_reg <= 1'b1;
          end else if (!fetch_en) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl. The ROM model returns 0xC0DE00xx where
// xx is the word index, so expected instruction words are known by hand.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  fifo_count;
  logic        fault;
  logic [15:0] retire_cnt;

  int passed = 0;
  int total  = 0;

  ifetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2),
    .ROM_WORDS (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .fifo_count    (fifo_count),
    .fault         (fault),
    .retire_cnt    (retire_cnt)
  );

  assign rom_inst = 32'hC0DE_0000 | {26'd0, rom_addr[7:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs
  // driven 1 time unit after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else passed++;
    total++; if (out_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", out_inst); else passed++;
    total++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", out_pc); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", fault); else passed++;
    total++; if (retire_cnt !== 16'd0) $display("FAIL reset_retire got %0d want 0", retire_cnt); else passed++;
    total++; if (rom_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", rom_addr); else passed++;
    // Idle: nothing fetched even with time passing.
    tick(2);
    total++; if (fifo_count !== 2'd0) $display("FAIL idle_count got %0d want 0", fifo_count); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_fetch_run();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick(1);  // edge N: enter RUN
    total++; if (out_valid !== 1'b0) $display("FAIL run_first_valid got %0b want 0", out_valid); else passed++;
    tick(1);  // edge N+1: first push
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL run_valid[%0d] got %0b want 1", k, out_valid); else passed++;
      total++; if (out_pc !== 32'(4 * k)) $display("FAIL run_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); else passed++;
      total++; if (out_inst !== (32'hC0DE_0000 + 32'(k))) $display("FAIL run_inst[%0d] got %h want %h", k, out_inst, 32'hC0DE_0000 + 32'(k)); else passed++;
      total++; if (retire_cnt !== 16'(k)) $display("FAIL run_retire[%0d] got %0d want %0d", k, retire_cnt, k); else passed++;
      $display("run: pc=%h inst=%h retire=%0d", out_pc, out_inst, retire_cnt);
      tick(1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(2);
    total++; if (fifo_count !== 2'd1) $display("FAIL bp_count1 got %0d want 1", fifo_count); else passed++;
    tick(1);
    total++; if (fifo_count !== 2'd2) $display("FAIL bp_count2 got %0d want 2", fifo_count); else passed++;
    total++; if (rom_addr !== 32'h8) $display("FAIL bp_addr got %h want 8", rom_addr); else passed++;
    tick(2);
    total++; if (fifo_count !== 2'd2) $display("FAIL bp_hold_count got %0d want 2", fifo_count); else passed++;
    total++; if (rom_addr !== 32'h8) $display("FAIL bp_hold_addr got %h want 8", rom_addr); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (out_pc !== 32'(4 * k)) $display("FAIL bp_drain_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); else passed++;
      $display("bp drain: pc=%h count=%0d", out_pc, fifo_count);
      tick(1);
    end
    total++; if (retire_cnt !== 16'd4) $display("FAIL bp_retire got %0d want 4", retire_cnt); else passed++;
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(3);  // queue full with PCs 0x00/0x04
    total++; if (fifo_count !== 2'd2) $display("FAIL rd_full got %0d want 2", fifo_count); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h48; out_ready = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL rd_valid got %0b want 0", out_valid); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL rd_count got %0d want 0", fifo_count); else passed++;
    total++; if (retire_cnt !== 16'd0) $display("FAIL rd_retire got %0d want 0", retire_cnt); else passed++;
    total++; if (rom_addr !== 32'h48) $display("FAIL rd_addr got %h want 48", rom_addr); else passed++;
    tick(1);
    total++; if (out_pc !== 32'h48) $display("FAIL rd_head_pc got %h want 48", out_pc); else passed++;
    total++; if (out_inst !== 32'hC0DE_0012) $display("FAIL rd_head_inst got %h want c0de0012", out_inst); else passed++;
    $display("redirect: head pc=%h inst=%h", out_pc, out_inst);
  endtask

  task automatic test_misaligned();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(2);  // one entry queued, pc = 0x04
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    tick(1);
    redirect_valid = 1'b0;
    total++; if (fault !== 1'b1) $display("FAIL mis_fault got %0b want 1", fault); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL mis_count got %0d want 0", fifo_count); else passed++;
    total++; if (rom_addr !== 32'h4) $display("FAIL mis_addr got %h want 4", rom_addr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(1);
    redirect_valid = 1'b0; fetch_en = 1'b0;
    tick(1);
    fetch_en = 1'b1;
    tick(2);
    total++; if (rom_addr !== 32'h4) $display("FAIL mis_stuck_addr got %h want 4", rom_addr); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL mis_stuck_count got %0d want 0", fifo_count); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL mis_stuck_fault got %0b want 1", fault); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (fault !== 1'b0) $display("FAIL mis_reset_fault got %0b want 0", fault); else passed++;
    rst_n = 1'b1;
    $display("misaligned: fault cleared by reset");
  endtask

  task automatic test_out_of_range();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(1);  // RUN
    redirect_valid = 1'b1; redirect_pc = 32'hFC;
    tick(1);
    redirect_valid = 1'b0;
    total++; if (rom_addr !== 32'hFC) $display("FAIL oor_addr got %h want fc", rom_addr); else passed++;
    tick(1);  // push 0xFC
    total++; if (rom_addr !== 32'h100) $display("FAIL oor_addr2 got %h want 100", rom_addr); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL oor_early_fault got %0b want 0", fault); else passed++;
    tick(1);  // trap
    total++; if (fault !== 1'b1) $display("FAIL oor_fault got %0b want 1", fault); else passed++;
    total++; if (fifo_count !== 2'd1) $display("FAIL oor_count got %0d want 1", fifo_count); else passed++;
    total++; if (rom_addr !== 32'h100) $display("FAIL oor_hold_addr got %h want 100", rom_addr); else passed++;
    out_ready = 1'b1;
    #1;
    total++; if (out_pc !== 32'hFC) $display("FAIL oor_head_pc got %h want fc", out_pc); else passed++;
    total++; if (out_inst !== 32'hC0DE_003F) $display("FAIL oor_head_inst got %h want c0de003f", out_inst); else passed++;
    tick(1);
    total++; if (out_valid !== 1'b0) $display("FAIL oor_drained got %0b want 0", out_valid); else passed++;
    total++; if (retire_cnt !== 16'd1) $display("FAIL oor_retire got %0d want 1", retire_cnt); else passed++;
    tick(1);
    total++; if (out_valid !== 1'b0) $display("FAIL oor_no_dup got %0b want 0", out_valid); else passed++;
    $display("out_of_range: fault=%0b retire=%0d", fault, retire_cnt);
  endtask

  task automatic test_async_reset();
    apply_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick(4);  // two retired
    out_ready = 1'b0;
    tick(1);  // full again
    total++; if (fifo_count !== 2'd2) $display("FAIL ar_pre_count got %0d want 2", fifo_count); else passed++;
    total++; if (retire_cnt !== 16'd2) $display("FAIL ar_pre_retire got %0d want 2", retire_cnt); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %0b want 0", out_valid); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL ar_count got %0d want 0", fifo_count); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL ar_fault got %0b want 0", fault); else passed++;
    total++; if (retire_cnt !== 16'd0) $display("FAIL ar_retire got %0d want 0", retire_cnt); else passed++;
    total++; if (rom_addr !== 32'h0) $display("FAIL ar_addr got %h want 0", rom_addr); else passed++;
    $display("async_reset: count=%0d addr=%h", fifo_count, rom_addr);
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_run();
    test_backpressure();
    test_redirect_flush();
    test_misaligned();
    test_out_of_range();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
